barcode_scan_encoder: RTL and testbench
=======================================

# barcode_scan_encoder

Sequential driver for the 7-row barcode LED matrix decoder. It accepts a frame of seven BCD digits over a valid/ready handshake and encodes each digit to its 2-of-5 column code. It then refreshes the matrix one row at a time, driving the 3-bit row select (E7..E5) and the 5-bit code (E4..E0) that the matrix decoder consumes. Frames are double-buffered: a new frame is loaded in the background and committed only at a frame boundary.

## Interface
Parameters:
- TICK_DIV, 50000: clock cycles each row is driven; must be ≥1.
- GAP_CYC, 2: blanking cycles between rows (sel=000, code=00000); 0 allowed.

Ports:
- clk  in  1  system clock; one clock domain; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  digit presented.
- load_ready  out  1  block can accept a digit.
- digit  in  4  BCD digit; 10..15 are invalid.
- sel  out  3  row select to matrix (E7..E5); 001..111 = rows 0..6; 000 = no row.
- code  out  5  column code to matrix (E4..E0).
- frame_start  out  1  one-cycle pulse when row 0 begins driving.
- bad_digit  out  1  one-cycle pulse on acceptance of a digit >9.

## Operation
- 2-of-5 code, digit→E4..E0:
  - 0 = 00110, 1 = 10001, 2 = 01001, 3 = 11000, 4 = 00101
  - 5 = 10100, 6 = 01100, 7 = 00011, 8 = 10010, 9 = 01010
  - Invalid digits encode as 00000, which the decoder rejects, so that row's columns stay dark.
- Shadow buffer: 7 entries filled in order via a write index 0..6.
  - A digit is accepted on a cycle with load_valid && load_ready.
  - Acceptance at index 6 sets `pending`, resets the index to 0, and drops load_ready.
- Commit: the active buffer is replaced by the shadow and `pending` is cleared. Commit happens:
  - in IDLE, on the cycle after `pending` sets;
  - in scan states, at the end of the gap (or drive, if GAP_CYC=0) that follows row 6.
- FSM states:
  - IDLE: sel=000, code=00000. Leaves to DRIVE(row 0) on commit.
  - DRIVE: sel=row+1, code=enc(active[row]), held TICK_DIV cycles. Then goes to GAP, or straight to the next row if GAP_CYC=0.
  - GAP: sel=000, code=00000 for GAP_CYC cycles. Then goes to DRIVE(row+1), wrapping 6→0. A commit, if pending, occurs at the 6→0 wrap.
- Once committed, scanning never returns to IDLE except by reset. With no new frame, the active frame repeats indefinitely.

## Timing
- Reset values:
  - sel=000, code=00000, load_ready=1, frame_start=0, bad_digit=0
  - state IDLE, row=0, write index 0, pending=0, both buffers cleared.
- All outputs are registered.
- IDLE load latency: 7th digit accepted at edge k → at edge k+1:
  - commit occurs and DRIVE starts;
  - sel=001, code=enc(d0), frame_start=1 for that cycle;
  - load_ready is 0 after edge k and 1 again after edge k+1.
- Frame period: 7·(TICK_DIV+GAP_CYC) cycles; frame_start pulses once per period.
- Scanning load: load_ready stays 0 from the 7th acceptance until the commit edge at the row 6→0 wrap; it is 1 again the following cycle.
- Loading never alters the active buffer mid-frame.
- Simultaneous events:
  - Commit and acceptance cannot coincide, because load_ready=0 while pending.
  - A frame_start and a commit on the same edge show the new frame's row 0.
- Reset mid-operation: a partial shadow frame and the pending flag are discarded; the block returns to IDLE on the next edge.
- Counter widths: $clog2(TICK_DIV+1) and $clog2(GAP_CYC+1); the row counter is 3 bits and wraps at 6.

## Structure
- Package barcode_pkg:
  - ROW_COUNT=7;
  - 5-bit code constants for digits 0..9 and CODE_BLANK=00000;
  - SEL_NONE=000;
  - FSM state enum {IDLE, DRIVE, GAP}.
- Sub-module two_of_five_encoder: combinational, digit[3:0] → code[4:0] plus valid flag. Its valid output drives bad_digit.
- The top level contains the handshake, the shadow and active buffers, the FSM, and the counters.

## Test plan
All scenarios use TICK_DIV=4 and GAP_CYC=1.
- Reset, then load 1,2,3,4,5,6,7 back-to-back → the cycle after the 7th accept: sel=001, code=10001, frame_start=1. Row 1 appears 5 cycles later with sel=010, code=01001.
- Full frame observation → rows 001..111 each held 4 cycles with one 000 gap between rows. frame_start repeats every 35 cycles.
- Load 9,9,9,9,9,9,9 while frame 0..6 is scanning → the old frame completes unchanged, and load_ready=0 until the wrap. The next row 0 shows code=01010, and load_ready=1 the following cycle.
- Load 12 in slot 3 → bad_digit pulses at acceptance; row 3 shows sel=100, code=00000.
- Assert rst during row 4 after 3 of 7 new digits have been loaded → next cycle: sel=000, code=00000, IDLE. A fresh 7-digit load is required before any row drives.
- load_valid held with load_ready=0 → no acceptance, and the write index is unchanged.

Source files
------------

// File: rtl/barcode_pkg.sv
// Shared constants and types for the barcode matrix scan driver.
// Column codes are listed in E4..E0 order as the matrix decoder expects them.
package barcode_pkg;

    localparam int ROW_COUNT = 7;

    localparam logic [4:0] CODE_D0    = 5'b00110;
    localparam logic [4:0] CODE_D1    = 5'b10001;
    localparam logic [4:0] CODE_D2    = 5'b01001;
    localparam logic [4:0] CODE_D3    = 5'b11000;
    localparam logic [4:0] CODE_D4    = 5'b00101;
    localparam logic [4:0] CODE_D5    = 5'b10100;
    localparam logic [4:0] CODE_D6    = 5'b01100;
    localparam logic [4:0] CODE_D7    = 5'b00011;
    localparam logic [4:0] CODE_D8    = 5'b10010;
    localparam logic [4:0] CODE_D9    = 5'b01010;
    localparam logic [4:0] CODE_BLANK = 5'b00000;

    localparam logic [2:0] SEL_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } scanState_t;

endpackage

// File: rtl/barcode_scan_encoder_encoder.sv
// Combinational BCD to 2-of-5 column code converter.
// Digits above 9 produce the blank code, which the matrix decoder treats as dark.
module two_of_five_encoder
    import barcode_pkg::*;
(
    input  logic [3:0] digit,
    output logic [4:0] code,
    output logic       valid
);

    always_comb begin
        code  = CODE_BLANK;
        valid = 1'b1;
        case (digit)
            4'd0:    code = CODE_D0;
            4'd1:    code = CODE_D1;
            4'd2:    code = CODE_D2;
            4'd3:    code = CODE_D3;
            4'd4:    code = CODE_D4;
            4'd5:    code = CODE_D5;
            4'd6:    code = CODE_D6;
            4'd7:    code = CODE_D7;
            4'd8:    code = CODE_D8;
            4'd9:    code = CODE_D9;
            default: begin
                code  = CODE_BLANK;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/barcode_scan_encoder.sv
// Row-scanning driver for the 7-row barcode LED matrix with a double-buffered frame.
// Digits are encoded on entry, so both buffers hold ready-to-drive column codes.
module barcode_scan_encoder
    import barcode_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int GAP_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [3:0] digit,
    output logic [2:0] sel,
    output logic [4:0] code,
    output logic       frame_start,
    output logic       bad_digit
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;
    localparam logic [2:0]    LAST_ROW  = 3'(ROW_COUNT - 1);

    scanState_t    state;
    scanState_t    nextState;
    logic [2:0]    row;
    logic [2:0]    nextRow;
    logic [2:0]    followingRow;
    logic [TW-1:0] tickCnt;
    logic [TW-1:0] nextTick;
    logic [GW-1:0] gapCnt;
    logic [GW-1:0] nextGap;
    logic          commit;
    logic          frameBegin;

    logic [2:0]    wrIdx;
    logic          pending;
    logic          accept;
    logic [4:0]    inCode;
    logic          inValid;
    logic [4:0]    shadowCode [ROW_COUNT];
    logic [4:0]    activeCode [ROW_COUNT];
    logic [4:0]    showCode;

    two_of_five_encoder digitEncoder (
        .digit (digit),
        .code  (inCode),
        .valid (inValid)
    );

    assign accept       = load_valid && load_ready;
    assign followingRow = (row == LAST_ROW) ? 3'd0 : row + 3'd1;

    // Next-state logic; a pending frame is only swapped in when row 0 is about to start.
    always_comb begin
        nextState  = state;
        nextRow    = row;
        nextTick   = tickCnt;
        nextGap    = gapCnt;
        commit     = 1'b0;
        frameBegin = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    commit     = 1'b1;
                    frameBegin = 1'b1;
                    nextState  = DRIVE;
                    nextRow    = 3'd0;
                    nextTick   = '0;
                end
            end
            DRIVE: begin
                if (tickCnt == TICK_LAST) begin
                    if (GAP_CYC > 0) begin
                        nextState = GAP;
                        nextGap   = '0;
                    end else begin
                        nextState  = DRIVE;
                        nextRow    = followingRow;
                        nextTick   = '0;
                        frameBegin = (row == LAST_ROW);
                        commit     = (row == LAST_ROW) && pending;
                    end
                end else begin
                    nextTick = tickCnt + TW'(1);
                end
            end
            GAP: begin
                if (gapCnt == GAP_LAST) begin
                    nextState  = DRIVE;
                    nextRow    = followingRow;
                    nextTick   = '0;
                    frameBegin = (row == LAST_ROW);
                    commit     = (row == LAST_ROW) && pending;
                end else begin
                    nextGap = gapCnt + GW'(1);
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // On a commit edge the outgoing code must come from the frame being committed.
    always_comb begin
        showCode = commit ? shadowCode[nextRow] : activeCode[nextRow];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row     <= 3'd0;
            tickCnt <= '0;
            gapCnt  <= '0;
        end else begin
            state   <= nextState;
            row     <= nextRow;
            tickCnt <= nextTick;
            gapCnt  <= nextGap;
        end
    end

    // Load side: fill the shadow in order, then hold off the source until the swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrIdx      <= 3'd0;
            pending    <= 1'b0;
            load_ready <= 1'b1;
            bad_digit  <= 1'b0;
            for (int i = 0; i < ROW_COUNT; i++) begin
                shadowCode[i] <= CODE_BLANK;
                activeCode[i] <= CODE_BLANK;
            end
        end else begin
            bad_digit <= accept && !inValid;
            if (commit) begin
                pending    <= 1'b0;
                load_ready <= 1'b1;
                for (int i = 0; i < ROW_COUNT; i++) begin
                    activeCode[i] <= shadowCode[i];
                end
            end
            if (accept) begin
                shadowCode[wrIdx] <= inCode;
                if (wrIdx == LAST_ROW) begin
                    wrIdx      <= 3'd0;
                    pending    <= 1'b1;
                    load_ready <= 1'b0;
                end else begin
                    wrIdx <= wrIdx + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel         <= SEL_NONE;
            code        <= CODE_BLANK;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frameBegin;
            if (nextState == DRIVE) begin
                sel  <= nextRow + 3'd1;
                code <= showCode;
            end else begin
                sel  <= SEL_NONE;
                code <= CODE_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_barcode_scan_encoder.sv
// Randomised and directed bench for barcode_scan_encoder against a frame-position model.
// The model tracks the position inside a 35-cycle frame rather than the FSM itself.
module tb_barcode_scan_encoder;

    localparam int TICK   = 4;
    localparam int GAPC   = 1;
    localparam int SLOT   = TICK + GAPC;
    localparam int PERIOD = 7 * SLOT;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] digit;
    logic [2:0] sel;
    logic [4:0] code;
    logic       frame_start;
    logic       bad_digit;

    int compares = 0;
    int errors   = 0;

    bit scanning;
    int pos;
    bit mPending;
    int mActive [7];
    int mFrame  [7];
    int shadowQ [$];
    logic [2:0] expSel;
    logic [4:0] expCode;
    logic       expReady;
    logic       expFs;
    logic       expBad;

    barcode_scan_encoder #(.TICK_DIV(TICK), .GAP_CYC(GAPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .digit       (digit),
        .sel         (sel),
        .code        (code),
        .frame_start (frame_start),
        .bad_digit   (bad_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Code bits E4..E0 carry weights 1,2,4,7,0; two bits set, summing to the digit (0 sums to 11).
    function automatic logic [4:0] twoOfFive(input int d);
        int w [5] = '{0, 7, 4, 2, 1};
        int target;
        logic [4:0] c;
        c = 5'b00000;
        if (d > 9) return c;
        target = (d == 0) ? 11 : d;
        for (int i = 0; i < 5; i++)
            for (int j = i + 1; j < 5; j++)
                if (w[i] + w[j] == target) begin
                    c[i] = 1'b1;
                    c[j] = 1'b1;
                end
        return c;
    endfunction

    task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compares++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkOne("sel", {5'b0, sel}, {5'b0, expSel});
        checkOne("code", {3'b0, code}, {3'b0, expCode});
        checkOne("load_ready", {7'b0, load_ready}, {7'b0, expReady});
        checkOne("frame_start", {7'b0, frame_start}, {7'b0, expFs});
        checkOne("bad_digit", {7'b0, bad_digit}, {7'b0, expBad});
    endtask

    task automatic modelEdge(input logic v, input int d, input logic r);
        bit readyBefore;
        readyBefore = !mPending;
        if (r) begin
            scanning = 0;
            pos      = 0;
            mPending = 0;
            shadowQ.delete();
            for (int i = 0; i < 7; i++) mActive[i] = 0;
            expBad = 1'b0;
        end else begin
            if (!scanning) begin
                if (mPending) begin
                    scanning = 1;
                    pos      = 0;
                    mActive  = mFrame;
                    mPending = 0;
                end
            end else begin
                pos = (pos + 1) % PERIOD;
                if (pos == 0 && mPending) begin
                    mActive  = mFrame;
                    mPending = 0;
                end
            end
            expBad = v && readyBefore && (d > 9);
            if (v && readyBefore) begin
                shadowQ.push_back(d);
                if (shadowQ.size() == 7) begin
                    for (int i = 0; i < 7; i++) mFrame[i] = shadowQ[i];
                    shadowQ.delete();
                    mPending = 1;
                end
            end
        end
        expReady = !mPending;
        expFs    = scanning && (pos == 0);
        if (scanning && (pos % SLOT) < TICK) begin
            expSel  = 3'(pos / SLOT + 1);
            expCode = twoOfFive(mActive[pos / SLOT]);
        end else begin
            expSel  = 3'b000;
            expCode = 5'b00000;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic r);
        rst        = r;
        load_valid = v;
        digit      = d;
        @(posedge clk);
        modelEdge(v, int'(d), r);
        #1;
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        logic [3:0] frameDigits [7];
        rst        = 1'b1;
        load_valid = 1'b0;
        digit      = 4'd0;
        scanning   = 0;
        pos        = 0;
        mPending   = 0;

        $display("[TB] reset and first frame 1..7");
        applyStimulus(1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b1);
        for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 4'(i), 1'b0);
        idleCycles(2 * PERIOD + 3);

        $display("[TB] background load 0..6 then 9s while scanning");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 4'(i), 1'b0);
        idleCycles(PERIOD + 4);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 4'd9, 1'b0);
        for (int i = 0; i < PERIOD + 5; i++) applyStimulus(1'b1, 4'd3, 1'b0);
        idleCycles(PERIOD);

        $display("[TB] invalid digit in slot 3");
        frameDigits = '{4'd5, 4'd6, 4'd7, 4'd12, 4'd8, 4'd9, 4'd0};
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, frameDigits[i], 1'b0);
        idleCycles(2 * PERIOD);

        $display("[TB] reset during row 4 with a partial frame");
        for (int i = 0; i < PERIOD && !(scanning && pos / SLOT == 4); i++)
            applyStimulus(1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'($urandom_range(0, 9)), 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1);
        idleCycles(PERIOD);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        idleCycles(PERIOD + 2);

        $display("[TB] random traffic");
        for (int i = 0; i < 30 * PERIOD; i++) begin
            applyStimulus(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 399) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
